// File: rtl/cache_sram_pkg.sv
// Shared constants and port-operation decode for the L1 cache memory block.
// Both arrays use active-low macro-style controls, decoded here once.
package cache_sram_pkg;

  localparam int DATA_DEPTH    = 64;
  localparam int DATA_WIDTH    = 128;
  localparam int DATA_AW       = 6;
  localparam int TAG_DEPTH     = 16;
  localparam int TAG_WIDTH     = 32;
  localparam int TAG_AW        = 4;
  localparam int TAG_VALID_BIT = 31;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_READ,
    PORT_WRITE
  } port_op_e;

  // An unknown chip select falls through to idle, so a floating csb never writes.
  function automatic port_op_e decode_op(input logic csb, input logic web);
    port_op_e op;
    op = PORT_IDLE;
    if (!csb) begin
      if (web) op = PORT_READ;
      else     op = PORT_WRITE;
    end
    return op;
  endfunction

endpackage

// File: rtl/sram_port_array.sv
// Behavioural synchronous SRAM array with one or two read/write ports,
// synchronous clear, and registered read data.
import cache_sram_pkg::*;

module sram_port_array #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 32,
  parameter bit DUAL_PORT = 1'b1,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p1_csb,
  input  logic             p1_web,
  input  logic [AW-1:0]    p1_a,
  input  logic [WIDTH-1:0] p1_i,
  output logic [WIDTH-1:0] p1_q,
  input  logic             p2_csb,
  input  logic             p2_web,
  input  logic [AW-1:0]    p2_a,
  input  logic [WIDTH-1:0] p2_i,
  output logic [WIDTH-1:0] p2_q
);

  logic [WIDTH-1:0] mem [DEPTH];
  port_op_e         op1;
  port_op_e         op2;

  assign op1 = decode_op(p1_csb, p1_web);

  if (DUAL_PORT) begin : g_dual
    assign op2 = decode_op(p2_csb, p2_web);
  end else begin : g_single
    logic unused_p2;
    assign op2       = PORT_IDLE;
    assign unused_p2 = ^{p2_csb, p2_web, p2_a, p2_i};
  end

  // Reads sample the array before this edge's writes land; port 1's write is
  // issued last so it wins when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      if (op1 == PORT_READ)  p1_q       <= mem[p1_a];
      if (op2 == PORT_READ)  p2_q       <= mem[p2_a];
      if (op2 == PORT_WRITE) mem[p2_a]  <= p2_i;
      if (op1 == PORT_WRITE) mem[p1_a]  <= p1_i;
    end
  end

endmodule

// File: rtl/cache_sram.sv
// L1 cache memory block: single-port line data array plus dual-port
// {valid, tag} array, with output-enable tristates on every read port.
import cache_sram_pkg::*;

module cache_sram (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_web,
  input  logic                  d_oeb,
  input  logic                  d_csb,
  input  logic [DATA_AW-1:0]    d_a,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] d_o,
  input  logic                  t1_web,
  input  logic                  t1_oeb,
  input  logic                  t1_csb,
  input  logic [TAG_AW-1:0]     t1_a,
  input  logic [TAG_WIDTH-1:0]  t1_i,
  output logic [TAG_WIDTH-1:0]  t1_o,
  input  logic                  t2_web,
  input  logic                  t2_oeb,
  input  logic                  t2_csb,
  input  logic [TAG_AW-1:0]     t2_a,
  input  logic [TAG_WIDTH-1:0]  t2_i,
  output logic [TAG_WIDTH-1:0]  t2_o
);

  logic [DATA_WIDTH-1:0] d_q;
  logic [DATA_WIDTH-1:0] d_unused_q;
  logic [TAG_WIDTH-1:0]  t1_q;
  logic [TAG_WIDTH-1:0]  t2_q;

  sram_port_array #(
    .DEPTH     (DATA_DEPTH),
    .WIDTH     (DATA_WIDTH),
    .DUAL_PORT (1'b0),
    .AW        (DATA_AW)
  ) u_data (
    .clk    (clk),
    .reset  (reset),
    .p1_csb (d_csb),
    .p1_web (d_web),
    .p1_a   (d_a),
    .p1_i   (d_i),
    .p1_q   (d_q),
    .p2_csb (1'b1),
    .p2_web (1'b1),
    .p2_a   ('0),
    .p2_i   ('0),
    .p2_q   (d_unused_q)
  );

  sram_port_array #(
    .DEPTH     (TAG_DEPTH),
    .WIDTH     (TAG_WIDTH),
    .DUAL_PORT (1'b1),
    .AW        (TAG_AW)
  ) u_tag (
    .clk    (clk),
    .reset  (reset),
    .p1_csb (t1_csb),
    .p1_web (t1_web),
    .p1_a   (t1_a),
    .p1_i   (t1_i),
    .p1_q   (t1_q),
    .p2_csb (t2_csb),
    .p2_web (t2_web),
    .p2_a   (t2_a),
    .p2_i   (t2_i),
    .p2_q   (t2_q)
  );

  assign d_o  = d_oeb  ? 'z : d_q;
  assign t1_o = t1_oeb ? 'z : t1_q;
  assign t2_o = t2_oeb ? 'z : t2_q;

endmodule

// File: tb/tb_cache_sram.sv
// Self-checking bench for cache_sram: directed scenarios followed by random
// traffic compared against a plain array model of both memories.
module tb_cache_sram;

  logic         clk = 1'b0;
  logic         reset;
  logic         d_web, d_oeb, d_csb;
  logic [5:0]   d_a;
  logic [127:0] d_i;
  wire  [127:0] d_o;
  logic         t1_web, t1_oeb, t1_csb;
  logic [3:0]   t1_a;
  logic [31:0]  t1_i;
  wire  [31:0]  t1_o;
  logic         t2_web, t2_oeb, t2_csb;
  logic [3:0]   t2_a;
  logic [31:0]  t2_i;
  wire  [31:0]  t2_o;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: array contents and the value each read port should show.
  logic [127:0] m_data [64];
  logic [31:0]  m_tag  [16];
  logic [127:0] exp_d;
  logic [31:0]  exp_t1, exp_t2;

  localparam logic [127:0] LINE = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;

  cache_sram dut (
    .clk(clk), .reset(reset),
    .d_web(d_web), .d_oeb(d_oeb), .d_csb(d_csb), .d_a(d_a), .d_i(d_i), .d_o(d_o),
    .t1_web(t1_web), .t1_oeb(t1_oeb), .t1_csb(t1_csb), .t1_a(t1_a), .t1_i(t1_i), .t1_o(t1_o),
    .t2_web(t2_web), .t2_oeb(t2_oeb), .t2_csb(t2_csb), .t2_a(t2_a), .t2_i(t2_i), .t2_o(t2_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  task automatic idle_all();
    reset = 1'b0;
    d_csb = 1'b1;  d_web = 1'b1;  d_oeb = 1'b0;  d_a = '0;  d_i = '0;
    t1_csb = 1'b1; t1_web = 1'b1; t1_oeb = 1'b0; t1_a = '0; t1_i = '0;
    t2_csb = 1'b1; t2_web = 1'b1; t2_oeb = 1'b0; t2_a = '0; t2_i = '0;
  endtask

  // Advance the model by the current inputs, clock the DUT, and compare enabled outputs.
  task automatic apply_stimulus();
    if (reset) begin
      for (int k = 0; k < 64; k++) m_data[k] = '0;
      for (int k = 0; k < 16; k++) m_tag[k] = '0;
      exp_d = '0; exp_t1 = '0; exp_t2 = '0;
    end else begin
      if (!d_csb && d_web)   exp_d  = m_data[d_a];
      if (!t1_csb && t1_web) exp_t1 = m_tag[t1_a];
      if (!t2_csb && t2_web) exp_t2 = m_tag[t2_a];
      if (!d_csb && !d_web)  m_data[d_a] = d_i;
      if (!t2_csb && !t2_web) m_tag[t2_a] = t2_i;
      if (!t1_csb && !t1_web) m_tag[t1_a] = t1_i;
    end
    @(posedge clk);
    #1;
    if (!d_oeb)  check_output("d_o", d_o, exp_d);
    if (!t1_oeb) check_output("t1_o", {96'b0, t1_o}, {96'b0, exp_t1});
    if (!t2_oeb) check_output("t2_o", {96'b0, t2_o}, {96'b0, exp_t2});
  endtask

  initial begin
    idle_all();
    reset = 1'b1;
    apply_stimulus();
    reset = 1'b0;

    // Post-reset reads return zero.
    t1_csb = 1'b0; t1_a = 4'd5; d_csb = 1'b0; d_a = 6'd63;
    apply_stimulus();
    check_output("rst_t1_addr5", {96'b0, t1_o}, 128'd0);
    check_output("rst_d_addr63", d_o, 128'd0);

    // Data write does not disturb the output register; next read sees the line.
    idle_all();
    d_csb = 1'b0; d_web = 1'b0; d_a = 6'd12; d_i = LINE;
    apply_stimulus();
    check_output("d_write_hold", d_o, 128'd0);
    d_web = 1'b1;
    apply_stimulus();
    check_output("d_read_back", d_o, LINE);

    // Both tag ports write addr 3: port 1 wins.
    idle_all();
    t1_csb = 1'b0; t1_web = 1'b0; t1_a = 4'd3; t1_i = 32'h8000_0042;
    t2_csb = 1'b0; t2_web = 1'b0; t2_a = 4'd3; t2_i = 32'h8000_0099;
    apply_stimulus();
    idle_all();
    t1_csb = 1'b0; t1_a = 4'd3;
    apply_stimulus();
    check_output("tag_ww_p1_wins", {96'b0, t1_o}, {96'b0, 32'h8000_0042});

    // Port 2 read during port 1 write sees the old value, then the new one.
    idle_all();
    t1_csb = 1'b0; t1_web = 1'b0; t1_a = 4'd7; t1_i = 32'h8000_0001;
    t2_csb = 1'b0; t2_a = 4'd7;
    apply_stimulus();
    check_output("tag_rw_old", {96'b0, t2_o}, 128'd0);
    t1_csb = 1'b1;
    apply_stimulus();
    check_output("tag_rw_new", {96'b0, t2_o}, {96'b0, 32'h8000_0001});

    // Deselected write is ignored.
    idle_all();
    d_web = 1'b0; d_a = 6'd12; d_i = ~LINE;
    apply_stimulus();
    d_csb = 1'b0; d_web = 1'b1;
    apply_stimulus();
    check_output("d_csb_blocks_write", d_o, LINE);

    // Output enable releases the pin without touching the held register.
    idle_all();
    d_oeb = 1'b1;
    #1;
    check_output("d_oeb_released", {127'b0, d_o !== LINE}, 128'd1);
    apply_stimulus();
    d_oeb = 1'b0;
    #1;
    check_output("d_oeb_restored", d_o, LINE);

    // Reset mid-stream wipes data, tags and valid bits.
    for (int k = 0; k < 4; k++) begin
      idle_all();
      d_csb = 1'b0; d_web = 1'b0; d_a = 6'(k); d_i = {4{32'hA5A5_0000 + 32'(k) + 1}};
      if (k == 0) begin
        t1_csb = 1'b0; t1_web = 1'b0; t1_a = 4'd2; t1_i = 32'h8000_1234;
      end
      apply_stimulus();
    end
    idle_all();
    reset = 1'b1;
    d_csb = 1'b0; d_web = 1'b0; d_a = 6'd1; d_i = LINE;
    apply_stimulus();
    for (int k = 0; k < 4; k++) begin
      idle_all();
      d_csb = 1'b0; d_a = 6'(k);
      t1_csb = 1'b0; t1_a = 4'd2;
      apply_stimulus();
      check_output("rst_mid_data", d_o, 128'd0);
      check_output("rst_mid_valid", {127'b0, t1_o[cache_sram_pkg::TAG_VALID_BIT]}, 128'd0);
    end

    // Random traffic; narrow tag addresses force frequent port collisions.
    for (int n = 0; n < 600; n++) begin
      reset  = ($urandom_range(0, 59) == 0);
      d_csb  = ($urandom_range(0, 3) == 0);
      d_web  = 1'($urandom_range(0, 1));
      d_oeb  = ($urandom_range(0, 7) == 0);
      d_a    = 6'($urandom_range(0, 15));
      d_i    = {$urandom, $urandom, $urandom, $urandom};
      t1_csb = ($urandom_range(0, 3) == 0);
      t1_web = 1'($urandom_range(0, 1));
      t1_oeb = ($urandom_range(0, 7) == 0);
      t1_a   = 4'($urandom_range(0, 5));
      t1_i   = $urandom;
      t2_csb = ($urandom_range(0, 3) == 0);
      t2_web = 1'($urandom_range(0, 1));
      t2_oeb = ($urandom_range(0, 7) == 0);
      t2_a   = 4'($urandom_range(0, 5));
      t2_i   = $urandom;
      apply_stimulus();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
